// File: rtl/enigma_grouper_if.sv
// Symbol stream in, grouped ready/valid stream out, for enigma_grouper.
// The slave modport is the grouper side; master is the driver side.
interface enigma_grouper_if;
    logic [7:0]        symb_numb_i;
    logic              symb_val_i;
    logic signed [6:0] symbol_i;
    logic              grp_rdy_i;
    logic              grp_val_o;
    logic signed [6:0] grp_symb_o;
    logic              grp_last_o;
    logic              ovf_o;

    modport slave (
        input  symb_numb_i, symb_val_i, symbol_i, grp_rdy_i,
        output grp_val_o, grp_symb_o, grp_last_o, ovf_o
    );

    modport master (
        output symb_numb_i, symb_val_i, symbol_i, grp_rdy_i,
        input  grp_val_o, grp_symb_o, grp_last_o, ovf_o
    );
endinterface

// File: rtl/enigma_grouper.sv
// Enigma output grouper: FIFO plus FSM that re-emits symbols in groups split by SPACE_CODE.
// Define ENIGMA_GRP_PAD_EN to pad an incomplete final group with PAD_CODE.
module enigma_grouper #(
    parameter int                GROUP_LEN  = 5,
    parameter int                FIFO_DEPTH = 16,
    parameter logic signed [6:0] SPACE_CODE = 7'sd32,
    parameter logic signed [6:0] PAD_CODE   = 7'sd23
) (
    input logic              clk_i,
    input logic              rst_i,
    enigma_grouper_if.slave  bus
);
    localparam int         AW      = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);
    localparam logic [3:0] GL_C    = 4'(GROUP_LEN);

`ifdef ENIGMA_GRP_PAD_EN
    typedef enum logic [1:0] {IDLE, SYMB, SPACE, PAD} state_t;
`else
    typedef enum logic [1:0] {IDLE, SYMB, SPACE} state_t;
    wire unused_pad_code = ^PAD_CODE;
`endif

    logic [7:0]  mem_q [FIFO_DEPTH];
    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    logic [7:0]  in_cnt_q, in_cnt_d;
    logic [8:0]  len_q, len_d;
    logic        ovf_q, ovf_d;

    state_t            state_q, state_d;
    logic [3:0]        pos_q, pos_d;
    logic              val_q, val_d;
    logic signed [6:0] symb_q, symb_d;
    logic              last_q, last_d;
    logic              ent_last_q, ent_last_d;

    logic       full, empty, wr_en, wr_last, pop, load_req, xfer;
    logic [8:0] cur_len;
    logic [7:0] rd_data;
    logic [3:0] p1;

    assign full    = (wr_ptr_q - rd_ptr_q) == DEPTH_C;
    assign empty   = wr_ptr_q == rd_ptr_q;
    assign rd_data = mem_q[rd_ptr_q[AW-1:0]];
    assign xfer    = val_q & bus.grp_rdy_i;

    // Length is sampled on the first symbol; 0 encodes 256.
    always_comb begin
        cur_len = len_q;
        if (in_cnt_q == 8'd0) begin
            cur_len = (bus.symb_numb_i == 8'd0) ? 9'd256
                                                : {1'b0, bus.symb_numb_i};
        end
        wr_last  = {1'b0, in_cnt_q} == (cur_len - 9'd1);
        wr_en    = bus.symb_val_i & ~full;
        len_d    = len_q;
        in_cnt_d = in_cnt_q;
        ovf_d    = ovf_q;
        if (bus.symb_val_i) begin
            len_d    = cur_len;
            in_cnt_d = wr_last ? 8'd0 : in_cnt_q + 8'd1;
            if (full) ovf_d = 1'b1;
        end
        wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, wr_en};
        rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, pop};
    end

    always_comb begin
        state_d    = state_q;
        pos_d      = pos_q;
        val_d      = val_q;
        symb_d     = symb_q;
        last_d     = last_q;
        ent_last_d = ent_last_q;
        pop        = 1'b0;
        load_req   = 1'b0;
        p1         = pos_q + 4'd1;
        unique case (state_q)
            IDLE: load_req = 1'b1;
            SYMB: begin
                if (xfer) begin
                    if (ent_last_q) begin
`ifdef ENIGMA_GRP_PAD_EN
                        if (p1 != GL_C) begin
                            pos_d   = p1;
                            state_d = PAD;
                            symb_d  = PAD_CODE;
                            last_d  = (p1 + 4'd1) == GL_C;
                        end else begin
                            pos_d    = 4'd0;
                            load_req = 1'b1;
                        end
`else
                        pos_d    = 4'd0;
                        load_req = 1'b1;
`endif
                    end else if (p1 == GL_C) begin
                        pos_d   = p1;
                        state_d = SPACE;
                        symb_d  = SPACE_CODE;
                        last_d  = 1'b0;
                    end else begin
                        pos_d    = p1;
                        load_req = 1'b1;
                    end
                end
            end
            SPACE: begin
                if (xfer) begin
                    pos_d    = 4'd0;
                    load_req = 1'b1;
                end
            end
`ifdef ENIGMA_GRP_PAD_EN
            PAD: begin
                if (xfer) begin
                    if (p1 == GL_C) begin
                        pos_d    = 4'd0;
                        load_req = 1'b1;
                    end else begin
                        pos_d  = p1;
                        last_d = (p1 + 4'd1) == GL_C;
                    end
                end
            end
`endif
            default: state_d = IDLE;
        endcase
        // Refill the output register from the FIFO, using the updated group position.
        if (load_req) begin
            if (!empty) begin
                pop        = 1'b1;
                val_d      = 1'b1;
                state_d    = SYMB;
                symb_d     = $signed(rd_data[6:0]);
                ent_last_d = rd_data[7];
`ifdef ENIGMA_GRP_PAD_EN
                last_d     = rd_data[7] && ((pos_d + 4'd1) == GL_C);
`else
                last_d     = rd_data[7];
`endif
            end else begin
                val_d   = 1'b0;
                last_d  = 1'b0;
                state_d = IDLE;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_en) mem_q[wr_ptr_q[AW-1:0]] <= {wr_last, bus.symbol_i};
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            in_cnt_q   <= '0;
            len_q      <= '0;
            ovf_q      <= 1'b0;
            state_q    <= IDLE;
            pos_q      <= '0;
            val_q      <= 1'b0;
            symb_q     <= '0;
            last_q     <= 1'b0;
            ent_last_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            in_cnt_q   <= in_cnt_d;
            len_q      <= len_d;
            ovf_q      <= ovf_d;
            state_q    <= state_d;
            pos_q      <= pos_d;
            val_q      <= val_d;
            symb_q     <= symb_d;
            last_q     <= last_d;
            ent_last_q <= ent_last_d;
        end
    end

    assign bus.grp_val_o  = val_q;
    assign bus.grp_symb_o = symb_q;
    assign bus.grp_last_o = last_q;
    assign bus.ovf_o      = ovf_q;
endmodule
